// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types and helpers for the fixed_point_* blocks: FSM state
// encoding and a generic arithmetic-shift / optional-saturate function.
package fixed_point_pkg;

  localparam int FP_MAX_W = 128;

  typedef enum logic [1:0] {
    FP_IDLE = 2'd0,
    FP_RUN  = 2'd1,
    FP_DONE = 2'd2
  } fp_state_e;

  typedef struct packed {
    logic signed [FP_MAX_W-1:0] value;
    logic                       ovf;
  } fp_res_t;

  // Floor-shift a wide product; when sat_en is set, clamp to an out_w-bit signed range.
  function automatic fp_res_t fp_shift_sat(input logic signed [FP_MAX_W-1:0] prod,
                                           input int                         shift,
                                           input int                         out_w,
                                           input logic                       sat_en);
    fp_res_t                    res;
    logic signed [FP_MAX_W-1:0] one;
    logic signed [FP_MAX_W-1:0] shifted;
    logic signed [FP_MAX_W-1:0] max_v;
    logic signed [FP_MAX_W-1:0] min_v;
    one     = 128'sd1;
    shifted = prod >>> shift;
    max_v   = (one <<< (out_w - 1)) - one;
    min_v   = ~max_v;
    res.value = shifted;
    res.ovf   = 1'b0;
    if (sat_en) begin
      if (shifted > max_v) begin
        res.value = max_v;
        res.ovf   = 1'b1;
      end else if (shifted < min_v) begin
        res.value = min_v;
        res.ovf   = 1'b1;
      end else begin
        res.value = shifted;
        res.ovf   = 1'b0;
      end
    end else begin
      res.value = shifted;
      res.ovf   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fixed_point_mul_shift.sv
// Combinational signed multiply, floor shift by EXTRA, then wrap or saturate to P_WIDTH.
module fixed_point_mul_shift
  import fixed_point_pkg::*;
#(
  parameter int   S_WIDTH = 16,
  parameter int   V_WIDTH = 16,
  parameter int   P_WIDTH = 16,
  parameter int   EXTRA   = 14,
  parameter logic SAT_EN  = 1'b0
) (
  input  logic signed [S_WIDTH-1:0] s_i,
  input  logic signed [V_WIDTH-1:0] v_i,
  output logic signed [P_WIDTH-1:0] p_o,
  output logic                      ovf_o
);

  localparam int PROD_W = S_WIDTH + V_WIDTH;

  logic signed [PROD_W-1:0]   prod_s;
  logic signed [FP_MAX_W-1:0] prod_ext_s;
  fp_res_t                    res_s;
  logic                       unused_hi_s;

  assign prod_s     = s_i * v_i;
  assign prod_ext_s = FP_MAX_W'(prod_s);
  assign res_s      = fp_shift_sat(prod_ext_s, EXTRA, P_WIDTH, SAT_EN);

  // Keeping only the low P_WIDTH bits is the wrap; saturated values already fit.
  assign p_o         = res_s.value[P_WIDTH-1:0];
  assign ovf_o       = res_s.ovf;
  assign unused_hi_s = ^res_s.value[FP_MAX_W-1:P_WIDTH];

endmodule

// File: rtl/fixed_point_slow_scale.sv
// Scales an N-element vector by a scalar, one element per cycle through a shared
// multiplier. Define FIXED_POINT_SLOW_SCALE_SAT_EN for saturation plus overflow_out.
module fixed_point_slow_scale
  import fixed_point_pkg::*;
#(
  parameter int S_WIDTH     = 16,
  parameter int S_FRAC_BITS = 14,
  parameter int V_WIDTH     = 16,
  parameter int V_FRAC_BITS = 14,
  parameter int P_WIDTH     = 16,
  parameter int P_FRAC_BITS = 14,
  parameter int N           = 3
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic signed [S_WIDTH-1:0]   S,
  input  logic signed [N*V_WIDTH-1:0] V,
  output logic                        valid_out,
  output logic signed [N*P_WIDTH-1:0] P,
  output logic                        overflow_out
);

  localparam int             EXTRA  = S_FRAC_BITS + V_FRAC_BITS - P_FRAC_BITS;
  localparam int             IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  I_LAST = IW'(N - 1);

`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  generate
    if (EXTRA < 0 || P_WIDTH > S_WIDTH + V_WIDTH || N < 1 || S_WIDTH + V_WIDTH > FP_MAX_W) begin : g_bad_cfg
      $fatal(1, "fixed_point_slow_scale: illegal width/fraction parameters");
    end
  endgenerate

  fp_state_e                   state_q, state_d;
  logic [IW-1:0]               i_q, i_d;
  logic signed [S_WIDTH-1:0]   s_q, s_d;
  logic signed [N*V_WIDTH-1:0] v_q, v_d;
  logic signed [N*P_WIDTH-1:0] p_q, p_d;
  logic                        accept_s;
  logic                        run_s;
  logic                        last_s;
  logic signed [V_WIDTH-1:0]   v_sel_s;
  logic signed [P_WIDTH-1:0]   elem_s;
  logic                        elem_ovf_s;

  assign accept_s = valid_in && ready_out;
  assign run_s    = (state_q == FP_RUN);
  assign last_s   = (i_q == I_LAST);
  assign v_sel_s  = v_q[i_q*V_WIDTH +: V_WIDTH];

  fixed_point_mul_shift #(
    .S_WIDTH (S_WIDTH),
    .V_WIDTH (V_WIDTH),
    .P_WIDTH (P_WIDTH),
    .EXTRA   (EXTRA),
    .SAT_EN  (SAT_EN)
  ) u_mul_shift (
    .s_i   (s_q),
    .v_i   (v_sel_s),
    .p_o   (elem_s),
    .ovf_o (elem_ovf_s)
  );

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= FP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FP_IDLE: begin
        if (accept_s) state_d = FP_RUN;
        else          state_d = FP_IDLE;
      end
      FP_RUN: begin
        if (last_s) state_d = FP_DONE;
        else        state_d = FP_RUN;
      end
      FP_DONE: begin
        if (accept_s) state_d = FP_RUN;
        else          state_d = FP_IDLE;
      end
      default: state_d = FP_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    ready_out = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      FP_IDLE: ready_out = 1'b1;
      FP_RUN:  ready_out = 1'b0;
      FP_DONE: begin
        ready_out = 1'b1;
        valid_out = 1'b1;
      end
      default: ready_out = 1'b0;
    endcase
  end

  // Operand capture, element index and result write-back
  always_comb begin
    s_d = s_q;
    v_d = v_q;
    i_d = i_q;
    p_d = p_q;
    if (accept_s) begin
      s_d = S;
      v_d = V;
      i_d = '0;
    end else if (run_s) begin
      p_d[i_q*P_WIDTH +: P_WIDTH] = elem_s;
      if (last_s) i_d = '0;
      else        i_d = i_q + IW'(1);
    end else begin
      p_d = p_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_q <= '0;
      v_q <= '0;
      i_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
      i_q <= i_d;
      p_q <= p_d;
    end
  end

  assign P = p_q;

`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
  logic ovf_q, ovf_d;

  // Overflow is cleared by each accept and sticks once any element clamps
  always_comb begin
    ovf_d = ovf_q;
    if (accept_s)                  ovf_d = 1'b0;
    else if (run_s && elem_ovf_s)  ovf_d = 1'b1;
    else                           ovf_d = ovf_q;
  end

  // Overflow register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_out = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = elem_ovf_s;
  assign overflow_out = 1'b0;
`endif

endmodule
